bpsk_frame_sequencer: RTL and testbench

Frame-level controller for the BPSK transmit path. On a start request it latches a payload word and drives the sine/modulator datapath through a preamble followed by the payload, MSB first. It paces every output sample through the DAC serializer's two-wire dav handshake. It sits between the debounced push-button/host logic and the sine datapath plus DAC serializer, in the role of the existing BPSK controller but frame-aware.

---
 rtl/bpsk_frame_sequencer_if.sv | 28 ++
 rtl/bpsk_frame_sequencer.sv | 136 +++++++++++++
 tb/tb_bpsk_frame_sequencer.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpsk_frame_sequencer_if.sv
// Handshake bundle between the frame sequencer, its host, the sine datapath and the DAC serializer.
// master = host/datapath/DAC side, slave = the sequencer itself.
`timescale 1ns/1ps
interface bpsk_frame_sequencer_if #(
  parameter int PAYLOAD_W = 16
);
  logic                 start;
  logic [PAYLOAD_W-1:0] payload;
  logic                 sine_rdy;
  logic                 davdac;
  logic                 sine_rst;
  logic                 sine_clk_en;
  logic                 mod_en;
  logic                 bit_out;
  logic                 dacdav;
  logic                 busy;
  logic                 done;

  modport master (
    output start, payload, sine_rdy, davdac,
    input  sine_rst, sine_clk_en, mod_en, bit_out, dacdav, busy, done
  );

  modport slave (
    input  start, payload, sine_rdy, davdac,
    output sine_rst, sine_clk_en, mod_en, bit_out, dacdav, busy, done
  );
endinterface

// File: rtl/bpsk_frame_sequencer.sv
// Frame sequencer for the BPSK transmit path: preamble then payload, MSB first, one DAC handshake per sample.
// Define DIFF_ENC_EN to send differentially encoded symbols (DBPSK) on bit_out.
`timescale 1ns/1ps
module bpsk_frame_sequencer #(
  parameter int                       PREAMBLE_BITS    = 8,
  parameter logic [PREAMBLE_BITS-1:0] PREAMBLE_PATTERN = 8'hAA,
  parameter int                       PAYLOAD_W        = 16,
  parameter int                       SAMPLES_PER_BIT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  bpsk_frame_sequencer_if.slave bus
);

  localparam int FRAME_BITS = PREAMBLE_BITS + PAYLOAD_W;
  localparam int SW         = $clog2(SAMPLES_PER_BIT + 1);
  localparam int BW         = $clog2(FRAME_BITS + 1);
  localparam logic [SW-1:0] SPB_CNT  = SW'(SAMPLES_PER_BIT);
  localparam logic [BW-1:0] BITS_CNT = BW'(FRAME_BITS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PHASE, ST_ADV, ST_WAIT_S, ST_REQ, ST_REL, ST_NEXT, ST_DONE
  } state_t;

  state_t                state;
  logic [SW-1:0]         sample_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  sine_rst, sine_clk_en, mod_en, bit_out, dacdav, busy, done;

  logic [FRAME_BITS-1:0] frame_word;
  logic [SW-1:0]         sample_nxt;
  logic [BW-1:0]         bit_nxt;
  logic                  sym_nxt;

  assign frame_word = {PREAMBLE_PATTERN, bus.payload};
  assign sample_nxt = sample_cnt + SW'(1);
  assign bit_nxt    = bit_cnt + BW'(1);

  // shreg[MSB] always holds the raw bit of the next symbol; bit_out doubles as the DBPSK encoder state
`ifdef DIFF_ENC_EN
  assign sym_nxt = bit_out ^ shreg[FRAME_BITS-1];
`else
  assign sym_nxt = shreg[FRAME_BITS-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      sample_cnt  <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      sine_rst    <= 1'b1;
      sine_clk_en <= 1'b0;
      mod_en      <= 1'b0;
      bit_out     <= 1'b0;
      dacdav      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start && !bus.davdac) begin
            shreg      <= {frame_word[FRAME_BITS-2:0], 1'b0};
            bit_out    <= frame_word[FRAME_BITS-1];
            sample_cnt <= '0;
            bit_cnt    <= '0;
            busy       <= 1'b1;
            mod_en     <= 1'b1;
            state      <= ST_PHASE;
          end
        end
        ST_PHASE: begin
          sine_rst    <= 1'b0;
          sine_clk_en <= 1'b1;
          state       <= ST_ADV;
        end
        ST_ADV: begin
          sine_clk_en <= 1'b0;
          state       <= ST_WAIT_S;
        end
        ST_WAIT_S: begin
          if (bus.sine_rdy) begin
            dacdav <= 1'b1;
            state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.davdac) begin
            dacdav <= 1'b0;
            state  <= ST_REL;
          end
        end
        ST_REL: begin
          if (!bus.davdac) state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (sample_nxt == SPB_CNT) begin
            sample_cnt <= '0;
            bit_cnt    <= bit_nxt;
            shreg      <= {shreg[FRAME_BITS-2:0], 1'b0};
            bit_out    <= sym_nxt;
            if (bit_nxt == BITS_CNT) begin
              done     <= 1'b1;
              mod_en   <= 1'b0;
              sine_rst <= 1'b1;
              state    <= ST_DONE;
            end else begin
              sine_clk_en <= 1'b1;
              state       <= ST_ADV;
            end
          end else begin
            sample_cnt  <= sample_nxt;
            sine_clk_en <= 1'b1;
            state       <= ST_ADV;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sine_rst    = sine_rst;
  assign bus.sine_clk_en = sine_clk_en;
  assign bus.mod_en      = mod_en;
  assign bus.bit_out     = bit_out;
  assign bus.dacdav      = dacdav;
  assign bus.busy        = busy;
  assign bus.done        = done;

endmodule

// File: tb/tb_bpsk_frame_sequencer.sv
// Directed bench for bpsk_frame_sequencer: 4-bit preamble 1010, 4-bit payload, 2 samples per bit,
// with a behavioural DAC serializer and sine datapath driving the handshake inputs.
`timescale 1ns/1ps
module tb_bpsk_frame_sequencer;

  localparam int PB  = 4;
  localparam int PW  = 4;
  localparam int SPB = 2;
  localparam int NS  = (PB + PW) * SPB;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  int   ack_delay;
  int   dac_hold;
  int   rdy_delay;

  int   n_hs, n_en, n_done, n_dhigh;
  int   en_while_ack, req_during_ack, bad_rdy, multi_hs, hs_since_en;
  bit   rdy_seen, dacdav_q;
  logic bits_rec [0:511];
  logic [7:0] exp_seq;

  bpsk_frame_sequencer_if #(.PAYLOAD_W(PW)) bus ();

  bpsk_frame_sequencer #(
    .PREAMBLE_BITS   (PB),
    .PREAMBLE_PATTERN(4'b1010),
    .PAYLOAD_W       (PW),
    .SAMPLES_PER_BIT (SPB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DAC serializer: ack after ack_delay cycles, hold ack at least dac_hold cycles and until the request drops
  initial begin : dac_model
    int wcnt;
    int hcnt;
    bus.davdac = 1'b0;
    wcnt = 0;
    hcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.davdac = 1'b0;
        wcnt = 0;
        hcnt = 0;
      end else if (bus.davdac) begin
        hcnt++;
        if (hcnt >= dac_hold && !bus.dacdav) begin
          bus.davdac = 1'b0;
          hcnt = 0;
        end
      end else if (bus.dacdav) begin
        if (wcnt >= ack_delay) begin
          bus.davdac = 1'b1;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Sine datapath: sine_rdy returns rdy_delay cycles after each advance pulse (0 = always ready)
  initial begin : sine_model
    int rcnt;
    bus.sine_rdy = 1'b1;
    rcnt = 0;
    forever begin
      @(negedge clk);
      if (rdy_delay == 0) begin
        bus.sine_rdy = 1'b1;
      end else if (bus.sine_clk_en) begin
        bus.sine_rdy = 1'b0;
        rcnt = rdy_delay;
      end else if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) bus.sine_rdy = 1'b1;
      end
    end
  end

  initial begin : monitor
    n_hs = 0; n_en = 0; n_done = 0; n_dhigh = 0;
    en_while_ack = 0; req_during_ack = 0; bad_rdy = 0; multi_hs = 0; hs_since_en = 0;
    rdy_seen = 1'b0;
    dacdav_q = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.sine_clk_en) begin
        n_en++;
        rdy_seen = 1'b0;
        hs_since_en = 0;
        if (bus.davdac) en_while_ack++;
      end else if (bus.sine_rdy) begin
        rdy_seen = 1'b1;
      end
      if (bus.dacdav) n_dhigh++;
      if (bus.dacdav && bus.davdac) req_during_ack++;
      if (bus.dacdav && !dacdav_q) begin
        if (!rdy_seen) bad_rdy++;
        if (hs_since_en != 0) multi_hs++;
        hs_since_en++;
        bits_rec[n_hs % 512] = bus.bit_out;
        n_hs++;
      end
      dacdav_q = bus.dacdav;
      if (bus.done) n_done++;
    end
  end

  task automatic start_frame(input logic [PW-1:0] p);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.payload = p;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.payload = 4'h5;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_hs(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (n_hs == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (bus.sine_rst !== 1'b1) begin
      errors++;
      $display("FAIL reset_sine_rst: got %b, want 1", bus.sine_rst);
    end
    checks++;
    if ({bus.sine_clk_en, bus.mod_en, bus.bit_out, bus.dacdav, bus.busy, bus.done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want 000000",
               {bus.sine_clk_en, bus.mod_en, bus.bit_out, bus.dacdav, bus.busy, bus.done});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({bus.busy, bus.sine_rst} !== 2'b01) begin
      errors++;
      $display("FAIL idle_after_reset: busy,sine_rst=%b, want 01", {bus.busy, bus.sine_rst});
    end
  endtask

  task automatic test_frame;
    int h0, e0, d0, dh0;
    bit ok;
    ack_delay = 1; dac_hold = 1; rdy_delay = 0;
    h0 = n_hs; e0 = n_en; d0 = n_done; dh0 = n_dhigh;
    start_frame(4'b0011);
    wait_done(2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_done_timeout: no done within 2000 cycles, want done");
    end
    checks++;
    if ({bus.busy, bus.mod_en, bus.sine_rst} !== 3'b101) begin
      errors++;
      $display("FAIL frame_done_state: busy,mod_en,sine_rst=%b, want 101",
               {bus.busy, bus.mod_en, bus.sine_rst});
    end
    @(posedge clk);
    #2;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("FAIL frame_busy_fall: busy,done=%b, want 00", {bus.busy, bus.done});
    end
    repeat (10) @(posedge clk);
    #2;
    checks++;
    if (n_hs - h0 != NS) begin
      errors++;
      $display("FAIL frame_handshakes: got %0d, want %0d", n_hs - h0, NS);
    end
    checks++;
    if (n_en - e0 != NS) begin
      errors++;
      $display("FAIL frame_clk_en: got %0d pulses, want %0d", n_en - e0, NS);
    end
    checks++;
    if (n_done - d0 != 1) begin
      errors++;
      $display("FAIL frame_done_count: got %0d, want 1", n_done - d0);
    end
    checks++;
    if (n_dhigh - dh0 != NS * 2) begin
      errors++;
      $display("FAIL frame_dacdav_cycles: got %0d, want %0d", n_dhigh - dh0, NS * 2);
    end
    for (int k = 0; k < NS; k++) begin
      checks++;
      if (bits_rec[(h0 + k) % 512] !== exp_seq[7 - k / SPB]) begin
        errors++;
        $display("FAIL frame_bit[%0d]: got %b, want %b", k, bits_rec[(h0 + k) % 512], exp_seq[7 - k / SPB]);
      end
    end
  endtask

  task automatic test_restart_ignored;
    int h0, d0, nbad;
    bit ok;
    ack_delay = 1; dac_hold = 1; rdy_delay = 0;
    h0 = n_hs; d0 = n_done;
    start_frame(4'b0011);
    wait_hs(h0 + 3, 500, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL restart_wait_hs: 3rd handshake not seen, want it within 500 cycles");
    end
    start_frame(4'hF);
    wait_done(2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL restart_done_timeout: no done within 2000 cycles, want done");
    end
    repeat (20) @(posedge clk);
    #2;
    checks++;
    if (n_hs - h0 != NS) begin
      errors++;
      $display("FAIL restart_handshakes: got %0d, want %0d", n_hs - h0, NS);
    end
    checks++;
    if (n_done - d0 != 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_single_frame: done pulses=%0d busy=%b, want 1 and 0", n_done - d0, bus.busy);
    end
    nbad = 0;
    for (int k = 0; k < NS; k++)
      if (bits_rec[(h0 + k) % 512] !== exp_seq[7 - k / SPB]) nbad++;
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL restart_bits: %0d wrong samples, want 0", nbad);
    end
  endtask

  task automatic test_slow_dac;
    int h0, ea0, rq0, dh0;
    bit ok;
    ack_delay = 2; dac_hold = 10; rdy_delay = 0;
    h0 = n_hs; ea0 = en_while_ack; rq0 = req_during_ack; dh0 = n_dhigh;
    start_frame(4'b0011);
    wait_done(5000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL slowdac_done_timeout: no done within 5000 cycles, want done");
    end
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (n_hs - h0 != NS) begin
      errors++;
      $display("FAIL slowdac_handshakes: got %0d, want %0d", n_hs - h0, NS);
    end
    checks++;
    if (en_while_ack - ea0 != 0) begin
      errors++;
      $display("FAIL slowdac_adv_during_ack: got %0d pulses, want 0", en_while_ack - ea0);
    end
    checks++;
    if (req_during_ack - rq0 != 0) begin
      errors++;
      $display("FAIL slowdac_req_during_ack: got %0d cycles, want 0", req_during_ack - rq0);
    end
    checks++;
    if (n_dhigh - dh0 != NS * 3) begin
      errors++;
      $display("FAIL slowdac_dacdav_cycles: got %0d, want %0d", n_dhigh - dh0, NS * 3);
    end
  endtask

  task automatic test_reset_midframe;
    int h0, d0, nbad;
    bit ok;
    ack_delay = 2; dac_hold = 1; rdy_delay = 0;
    h0 = n_hs;
    start_frame(4'b0011);
    wait_hs(h0 + 5, 500, ok);
    checks++;
    if (!ok || bus.dacdav !== 1'b1) begin
      errors++;
      $display("FAIL midrst_5th_sample: seen=%b dacdav=%b, want 1 1", ok, bus.dacdav);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.dacdav !== 1'b0) begin
      errors++;
      $display("FAIL midrst_dacdav: got %b, want 0", bus.dacdav);
    end
    checks++;
    if ({bus.mod_en, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_mod_en_busy: got %b, want 00", {bus.mod_en, bus.busy});
    end
    checks++;
    if (bus.sine_rst !== 1'b1) begin
      errors++;
      $display("FAIL midrst_sine_rst: got %b, want 1", bus.sine_rst);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 1;
    h0 = n_hs; d0 = n_done;
    start_frame(4'b0011);
    wait_done(2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midrst_done_timeout: no done within 2000 cycles, want done");
    end
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (n_hs - h0 != NS || n_done - d0 != 1) begin
      errors++;
      $display("FAIL midrst_refrench: handshakes=%0d done=%0d, want %0d and 1", n_hs - h0, n_done - d0, NS);
    end
    nbad = 0;
    for (int k = 0; k < NS; k++)
      if (bits_rec[(h0 + k) % 512] !== exp_seq[7 - k / SPB]) nbad++;
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL midrst_bits: %0d wrong samples, want 0", nbad);
    end
  endtask

  task automatic test_slow_sine;
    int h0, e0, br0, mh0, nbad;
    bit ok;
    ack_delay = 1; dac_hold = 1; rdy_delay = 3;
    h0 = n_hs; e0 = n_en; br0 = bad_rdy; mh0 = multi_hs;
    start_frame(4'b0011);
    wait_done(3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL slowsine_done_timeout: no done within 3000 cycles, want done");
    end
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (n_en - e0 != NS) begin
      errors++;
      $display("FAIL slowsine_clk_en: got %0d pulses, want %0d", n_en - e0, NS);
    end
    checks++;
    if (n_hs - h0 != NS) begin
      errors++;
      $display("FAIL slowsine_handshakes: got %0d, want %0d", n_hs - h0, NS);
    end
    checks++;
    if (bad_rdy - br0 != 0) begin
      errors++;
      $display("FAIL slowsine_req_before_rdy: got %0d, want 0", bad_rdy - br0);
    end
    checks++;
    if (multi_hs - mh0 != 0) begin
      errors++;
      $display("FAIL slowsine_extra_hs: got %0d, want 0", multi_hs - mh0);
    end
    nbad = 0;
    for (int k = 0; k < NS; k++)
      if (bits_rec[(h0 + k) % 512] !== exp_seq[7 - k / SPB]) nbad++;
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL slowsine_bits: %0d wrong samples, want 0", nbad);
    end
    rdy_delay = 0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    ack_delay = 1;
    dac_hold = 1;
    rdy_delay = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.payload = '0;
`ifdef DIFF_ENC_EN
    exp_seq = 8'b1100_0010;
`else
    exp_seq = 8'b1010_0011;
`endif
    test_reset();
    test_frame();
    test_restart_ignored();
    test_slow_dac();
    test_reset_midframe();
    test_slow_sine();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
